// File: rtl/mt_reg_file_if.sv
// Bus bundle for mt_reg_file: read ports, write port and bank-clear handshake.
// master = decode/write-back side, slave = the register file itself.
interface mt_reg_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int THREADS    = 2,
  parameter int DEPTH      = 32
);
  localparam int TID_W = $clog2(THREADS);
  localparam int RA_W  = $clog2(DEPTH);

  logic [TID_W-1:0]      rd_thread;
  logic                  uses_rs;
  logic                  uses_rt;
  logic [RA_W-1:0]       rs_addr;
  logic [RA_W-1:0]       rt_addr;
  logic [DATA_WIDTH-1:0] rs_data;
  logic [DATA_WIDTH-1:0] rt_data;
  logic [TID_W-1:0]      wr_thread;
  logic                  wr_en;
  logic [RA_W-1:0]       wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  clr_req;
  logic [TID_W-1:0]      clr_thread;
  logic                  clr_busy;
  logic                  clr_done;

  modport master (
    output rd_thread, uses_rs, uses_rt, rs_addr, rt_addr,
    output wr_thread, wr_en, wr_addr, wr_data, clr_req, clr_thread,
    input  rs_data, rt_data, clr_busy, clr_done
  );

  modport slave (
    input  rd_thread, uses_rs, uses_rt, rs_addr, rt_addr,
    input  wr_thread, wr_en, wr_addr, wr_data, clr_req, clr_thread,
    output rs_data, rt_data, clr_busy, clr_done
  );
endinterface

// File: rtl/mt_reg_file.sv
// Multithreaded MIPS register file: THREADS banks, 2 async reads, 1 sync write,
// with a zeroing sequencer. Define REG_FILE_BYPASS_EN for write-before-read forwarding.
module mt_reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int THREADS    = 2,
  parameter int DEPTH      = 32
) (
  input logic          clk,
  input logic          rst_n,
  mt_reg_file_if.slave bus
);
  localparam int TID_W   = $clog2(THREADS);
  localparam int RA_W    = $clog2(DEPTH);
  localparam int IDX_W   = TID_W + RA_W;
  localparam int ENTRIES = THREADS * DEPTH;

  typedef enum logic [1:0] {IDLE, INIT, CLEAR, DONE} state_t;

  state_t                state;
  state_t                next_state;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      next_idx;
  logic [TID_W-1:0]      clr_tid;
  logic [TID_W-1:0]      next_clr_tid;

  logic [DATA_WIDTH-1:0] regs [ENTRIES];

  logic                  user_wr_ok;
  logic                  arr_we;
  logic [IDX_W-1:0]      arr_waddr;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic                  rs_zero;
  logic                  rt_zero;
  logic [DATA_WIDTH-1:0] rs_val;
  logic [DATA_WIDTH-1:0] rt_val;

  // A user write survives unless it hits r0, lands in INIT, or targets the bank being cleared.
  always_comb begin
    user_wr_ok = bus.wr_en && (bus.wr_addr != '0);
    if (state == INIT) begin
      user_wr_ok = 1'b0;
    end
    if ((state == CLEAR) && (bus.wr_thread == clr_tid)) begin
      user_wr_ok = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= INIT;
      idx     <= '0;
      clr_tid <= '0;
    end else begin
      state   <= next_state;
      idx     <= next_idx;
      clr_tid <= next_clr_tid;
    end
  end

  // Single array write port: INIT always owns it, CLEAR yields to a surviving user write.
  always_comb begin
    next_state   = state;
    next_idx     = idx;
    next_clr_tid = clr_tid;
    arr_we       = user_wr_ok;
    arr_waddr    = {bus.wr_thread, bus.wr_addr};
    arr_wdata    = bus.wr_data;
    case (state)
      INIT: begin
        arr_we    = 1'b1;
        arr_waddr = idx;
        arr_wdata = '0;
        next_idx  = idx + 1'b1;
        if (idx == IDX_W'(ENTRIES - 1)) begin
          next_state = IDLE;
        end
      end
      IDLE: begin
        if (bus.clr_req) begin
          next_state   = CLEAR;
          next_clr_tid = bus.clr_thread;
          next_idx     = '0;
        end
      end
      CLEAR: begin
        if (!user_wr_ok) begin
          arr_we    = 1'b1;
          arr_waddr = {clr_tid, idx[RA_W-1:0]};
          arr_wdata = '0;
          next_idx  = idx + 1'b1;
          if (idx[RA_W-1:0] == RA_W'(DEPTH - 1)) begin
            next_state = DONE;
          end
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (arr_we) begin
      regs[arr_waddr] <= arr_wdata;
    end
  end

  // Zero rules override both the array and the optional forwarding path.
  always_comb begin
    rs_zero = !bus.uses_rs || (bus.rs_addr == '0) || (state == INIT) ||
              ((state == CLEAR) && (bus.rd_thread == clr_tid));
    rt_zero = !bus.uses_rt || (bus.rt_addr == '0) || (state == INIT) ||
              ((state == CLEAR) && (bus.rd_thread == clr_tid));
    rs_val  = regs[{bus.rd_thread, bus.rs_addr}];
    rt_val  = regs[{bus.rd_thread, bus.rt_addr}];
`ifdef REG_FILE_BYPASS_EN
    if (user_wr_ok && (bus.wr_thread == bus.rd_thread) && (bus.wr_addr == bus.rs_addr)) begin
      rs_val = bus.wr_data;
    end
    if (user_wr_ok && (bus.wr_thread == bus.rd_thread) && (bus.wr_addr == bus.rt_addr)) begin
      rt_val = bus.wr_data;
    end
`else
`endif
    if (rs_zero) begin
      rs_val = '0;
    end
    if (rt_zero) begin
      rt_val = '0;
    end
  end

  assign bus.rs_data  = rs_val;
  assign bus.rt_data  = rt_val;
  assign bus.clr_busy = (state == INIT) || (state == CLEAR);
  assign bus.clr_done = (state == DONE);

endmodule

// File: doc/mt_reg_file.md
# mt_reg_file

Parametrised multithreaded register file for the MIPS core: THREADS independent banks of DEPTH registers, each DATA_WIDTH bits, with two asynchronous read ports and one synchronous write port. It sits between decode and write-back, like the single-bank file it generalises. It adds a hardware zeroing sequencer that clears every bank after reset and clears any single bank on request, so a thread can be (re)started with a clean architectural state. Register 0 of every bank is hardwired to zero.

## Interface

Parameters:

- DATA_WIDTH, 32, bits per register
- THREADS, 2, number of register banks; power of two, ≥2
- DEPTH, 32, registers per bank; power of two, ≥2
- derived: TID_W = $clog2(THREADS), RA_W = $clog2(DEPTH)

Ports:

- clk  in  1  clock; everything is on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rd_thread  in  TID_W  bank addressed by both read ports
- uses_rs / uses_rt  in  1  read-port enables
- rs_addr / rt_addr  in  RA_W  read addresses
- rs_data / rt_data  out  DATA_WIDTH  read data, combinational
- wr_thread  in  TID_W  bank addressed by the write port
- wr_en  in  1  write enable (uses_rw)
- wr_addr  in  RA_W  write address
- wr_data  in  DATA_WIDTH  write data
- clr_req  in  1  request to zero bank clr_thread
- clr_thread  in  TID_W  bank to clear; sampled with clr_req
- clr_busy  out  1  sequencer is zeroing (INIT or CLEAR)
- clr_done  out  1  one-cycle pulse when a requested CLEAR completes

## Operation

Read rules (per port):

- Output is '0 if the port's enable is low, if the address is 0, or if the bank being read is being zeroed (the whole file in INIT; clr_thread in CLEAR).
- Otherwise the output is regs[{rd_thread, addr}].

Write rules:

- Writes to address 0 are dropped.
- Writes during INIT are dropped.
- Writes to the latched clear bank during CLEAR are dropped.

Sequencer FSM (states IDLE, INIT, CLEAR, DONE), with index counter idx of width TID_W+RA_W:

- **Reset:** while rst_n is low, state = INIT and idx = 0.
- **INIT:** zero entry idx each cycle, then idx++. After entry THREADS*DEPTH-1, go to IDLE. No clr_done pulse.
- **IDLE:** if clr_req is high, latch clr_thread, set idx[RA_W-1:0] = 0, and go to CLEAR. clr_req in any other state is ignored; it is not queued.
- **CLEAR:** zero entry {latched thread, idx}, then idx++. If an accepted wr_en targets another bank in the same cycle, that write wins: the sequencer stalls and holds idx. After entry DEPTH-1, go to DONE.
- **DONE:** clr_done = 1 for one cycle, then IDLE.

Other rules:

- The sequencer writes through the same single array write port; its write takes precedence only in INIT.
- Array contents are not reset by rst_n. Values are defined only after INIT completes.

## Timing

- Read latency is zero (combinational from address, enable, and state).
- A write is visible to reads from the cycle after the clk edge it was captured on.
- Output reset values: clr_busy = 1 (INIT), clr_done = 0, rs_data/rt_data = '0.
- INIT lasts exactly THREADS*DEPTH cycles after rst_n deasserts; clr_busy falls on the edge that enters IDLE.
- An unstalled CLEAR is accepted at edge N. clr_busy is high for cycles N+1 … N+DEPTH, clr_done is high in cycle N+DEPTH+1, and a new clr_req is accepted at edge N+DEPTH+2 at the earliest.
- Each stall extends CLEAR by one cycle.
- rst_n asserted mid-CLEAR or mid-INIT aborts immediately to INIT; no clr_done is issued.
- wr_en and clr_req in the same cycle (IDLE): the write commits, and CLEAR starts on the next cycle. If the write targets clr_thread, it is zeroed later by the clear.

## Configuration

REG_FILE_BYPASS_EN

- **Defined:** an accepted (not dropped) write whose {wr_thread, wr_addr} matches an enabled read's {rd_thread, addr} forwards wr_data to that read in the same cycle, i.e. write-before-read. The zero rules above still take priority.
- **Undefined:** a read in the same cycle as a matching write returns the old value.

## Test plan

- **Reset/INIT:** release rst_n with THREADS=2, DEPTH=32 -> clr_busy high for exactly 64 cycles. Then every {thread, addr} reads 0, and a write of 0xDEAD_BEEF to T0 r5 during INIT is dropped (reads 0).
- **Thread isolation:** write T0 r5 = 0x1111_1111 and T1 r5 = 0x2222_2222 -> rd_thread=0 gives 0x1111_1111 and rd_thread=1 gives 0x2222_2222. A write to r0 leaves it reading 0, and uses_rs = 0 gives 0.
- **Clear:** fill T1 r1..r31 with nonzero values, pulse clr_req with clr_thread = 1 -> clr_busy is high for 32 cycles and clr_done pulses on cycle 33. T1 then reads all zero while T0 is unchanged. During CLEAR, T1 reads 0 and writes to T1 are dropped.
- **Stall and ignore:** during CLEAR of T1, write T0 r3 on 4 separate cycles -> CLEAR takes 36 cycles and T0 r3 holds the last value. A second clr_req during CLEAR is ignored: only one clr_done.
- **Reset mid-CLEAR:** assert rst_n at CLEAR idx 10 -> no clr_done, and clr_busy stays high through a full 64-cycle INIT.
- **Bypass:** write T0 r7 = 0xA5A5_A5A5 while reading T0 r7 -> rs_data is 0xA5A5_A5A5 with REG_FILE_BYPASS_EN defined, and the old value when it is undefined.
